// File: rtl/npc_gen_pkg.sv
// -----------------------------------------------------------------------------
// npc_gen_pkg
// Shared IFU definitions used by the next-PC generator and its sub-modules.
//   npc_state_e       : fetch FSM state (BOOT / RUN / HOLD)
//   RESET_PC_DEFAULT  : default first fetch address after reset
//   FETCH_INC         : sequential fetch increment (one 32-bit instruction)
//   LINK_OFFSET       : return address offset of a linking branch (skips delay slot)
// Optional feature macro used by the files importing this package:
//   NPC_RAS_PREDICT_EN : enables return-address-stack prediction.
// -----------------------------------------------------------------------------
package npc_gen_pkg;

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2
   } npc_state_e;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
   localparam logic [31:0] FETCH_INC        = 32'd4;
   localparam logic [31:0] LINK_OFFSET      = 32'd8;

   // Sequential successor of a fetch address; wraps modulo 2^32.
   function automatic logic [31:0] seq_pc(input logic [31:0] pc);
      return pc + FETCH_INC;
   endfunction

endpackage

// File: rtl/npc_gen_if.sv
// -----------------------------------------------------------------------------
// npc_gen_if
// Bundles every non-clock/reset signal of the next-PC generator.
//   pause, recover, recover_pc       : stall and backend redirect
//   pd_*                             : predecode of the instruction fetched last cycle
//   ras_target                       : RAS top-of-stack
//   fetch_pc, fetch_valid            : current fetch address and its validity
//   ras_push, ras_pop, ras_link_pc   : RAS update request and push value
// Modports:
//   master : the next-PC generator (drives fetch_* and ras_push/pop/link_pc)
//   slave  : the surrounding pipeline (drives the stall/redirect/predecode side)
// -----------------------------------------------------------------------------
interface npc_gen_if;

   logic        pause;
   logic        recover;
   logic [31:0] recover_pc;
   logic        pd_valid;
   logic [31:0] pd_pc;
   logic        pd_isLink;
   logic        pd_isReturn;
   logic        pd_isJump;
   logic [31:0] pd_jump_target;
   logic [31:0] ras_target;
   logic [31:0] fetch_pc;
   logic        fetch_valid;
   logic        ras_push;
   logic        ras_pop;
   logic [31:0] ras_link_pc;

   modport master (
      input  pause, recover, recover_pc,
      input  pd_valid, pd_pc, pd_isLink, pd_isReturn, pd_isJump, pd_jump_target,
      input  ras_target,
      output fetch_pc, fetch_valid, ras_push, ras_pop, ras_link_pc
   );

   modport slave (
      output pause, recover, recover_pc,
      output pd_valid, pd_pc, pd_isLink, pd_isReturn, pd_isJump, pd_jump_target,
      output ras_target,
      input  fetch_pc, fetch_valid, ras_push, ras_pop, ras_link_pc
   );

endinterface

// File: rtl/npc_target_sel.sv
// -----------------------------------------------------------------------------
// npc_target_sel
// Purely combinational redirect-target selection from predecode flags.
//   is_link, is_return, is_jump, jump_target : predecode fields
//   ras_target                               : RAS top-of-stack
//   redirect, target                         : redirect request and address
//   push_req, pop_req                        : RAS update implied by the instruction
// With NPC_RAS_PREDICT_EN defined a return redirects to ras_target and link /
// return request a RAS push / pop (both for jalr ra,ra: pop-then-push).
// Without it returns are not predicted, the RAS is never touched, and only
// jumps / links redirect (to jump_target).
// -----------------------------------------------------------------------------
module npc_target_sel (
   input  logic        is_link,
   input  logic        is_return,
   input  logic        is_jump,
   input  logic [31:0] jump_target,
   input  logic [31:0] ras_target,
   output logic        redirect,
   output logic [31:0] target,
   output logic        push_req,
   output logic        pop_req
);

`ifdef NPC_RAS_PREDICT_EN
   always_comb begin
      redirect = 1'b0;
      target   = jump_target;
      if (is_return) begin
         redirect = 1'b1;
         target   = ras_target;
      end else if (is_jump || is_link) begin
         redirect = 1'b1;
         target   = jump_target;
      end
   end

   assign push_req = is_link;
   assign pop_req  = is_return;
`else
   // Return prediction is compiled out; these inputs are intentionally ignored.
   logic unused_ras;
   assign unused_ras = ^{ras_target, is_return};

   assign redirect = is_jump | is_link;
   assign target   = jump_target;
   assign push_req = 1'b0;
   assign pop_req  = 1'b0;
`endif

endmodule

// File: rtl/npc_gen.sv
// -----------------------------------------------------------------------------
// npc_gen
// Next fetch-PC generator with predecode-driven redirects and RAS updates.
//   clk  : sole clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : npc_gen_if.master (stall/recover/predecode in, fetch_pc/RAS out)
// Parameter RESET_PC: first fetch address after reset.
// Optional macro NPC_RAS_PREDICT_EN: enables return prediction via the RAS.
// A redirect seen while stalled is parked in HOLD together with its RAS update
// so the update is issued exactly once, on the cycle the stall clears.
// -----------------------------------------------------------------------------
module npc_gen
   import npc_gen_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic      clk,
   input  logic      rst,
   npc_gen_if.master bus
);

   npc_state_e  state_reg,      state_next;
   logic [31:0] fetch_pc_reg,   fetch_pc_next;
   logic [31:0] pending_pc_reg, pending_pc_next;
   logic [31:0] pend_link_reg,  pend_link_next;
   logic        pend_push_reg,  pend_push_next;
   logic        pend_pop_reg,   pend_pop_next;

   logic        sel_redirect;
   logic [31:0] sel_target;
   logic        sel_push;
   logic        sel_pop;
   logic        accepted;
   logic        take;
   logic        hold_exit;

   npc_target_sel u_target_sel (
      .is_link     (bus.pd_isLink),
      .is_return   (bus.pd_isReturn),
      .is_jump     (bus.pd_isJump),
      .jump_target (bus.pd_jump_target),
      .ras_target  (bus.ras_target),
      .redirect    (sel_redirect),
      .target      (sel_target),
      .push_req    (sel_push),
      .pop_req     (sel_pop)
   );

   // Predecode only counts if it describes the instruction just before the
   // current fetch (i.e. the current fetch is its delay slot).
   assign accepted  = bus.pd_valid && (seq_pc(bus.pd_pc) == fetch_pc_reg)
                      && (state_reg == ST_RUN) && !bus.recover;
   assign take      = accepted && sel_redirect;
   assign hold_exit = (state_reg == ST_HOLD) && !bus.pause && !bus.recover;

   assign bus.fetch_pc    = fetch_pc_reg;
   assign bus.fetch_valid = (state_reg != ST_BOOT);
   assign bus.ras_push    = (accepted && sel_push && !bus.pause) || (hold_exit && pend_push_reg);
   assign bus.ras_pop     = (accepted && sel_pop  && !bus.pause) || (hold_exit && pend_pop_reg);
   // During HOLD the predecode has moved on, so the parked link address is shown.
   assign bus.ras_link_pc = (state_reg == ST_HOLD) ? pend_link_reg : (bus.pd_pc + LINK_OFFSET);

   always_comb begin
      state_next      = state_reg;
      fetch_pc_next   = fetch_pc_reg;
      pending_pc_next = pending_pc_reg;
      pend_link_next  = pend_link_reg;
      pend_push_next  = pend_push_reg;
      pend_pop_next   = pend_pop_reg;

      if (bus.recover) begin
         state_next      = ST_RUN;
         fetch_pc_next   = bus.recover_pc;
         pending_pc_next = '0;
         pend_push_next  = 1'b0;
         pend_pop_next   = 1'b0;
      end else begin
         case (state_reg)
            ST_BOOT: state_next = ST_RUN;
            ST_RUN: begin
               if (!bus.pause) begin
                  fetch_pc_next = take ? sel_target : seq_pc(fetch_pc_reg);
               end else if (take) begin
                  state_next      = ST_HOLD;
                  pending_pc_next = sel_target;
                  pend_link_next  = bus.pd_pc + LINK_OFFSET;
                  pend_push_next  = sel_push;
                  pend_pop_next   = sel_pop;
               end
            end
            ST_HOLD: begin
               if (!bus.pause) begin
                  state_next     = ST_RUN;
                  fetch_pc_next  = pending_pc_reg;
                  pend_push_next = 1'b0;
                  pend_pop_next  = 1'b0;
               end
            end
            default: state_next = ST_BOOT;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg      <= ST_BOOT;
         fetch_pc_reg   <= RESET_PC;
         pending_pc_reg <= '0;
         pend_link_reg  <= '0;
         pend_push_reg  <= 1'b0;
         pend_pop_reg   <= 1'b0;
      end else begin
         state_reg      <= state_next;
         fetch_pc_reg   <= fetch_pc_next;
         pending_pc_reg <= pending_pc_next;
         pend_link_reg  <= pend_link_next;
         pend_push_reg  <= pend_push_next;
         pend_pop_reg   <= pend_pop_next;
      end
   end

endmodule

// File: tb/tb_npc_gen.sv
// -----------------------------------------------------------------------------
// tb_npc_gen
// Table-driven bench for npc_gen. Each table row is one clock cycle: inputs are
// applied after the falling edge, the expected outputs for that cycle are queued,
// and they are popped and compared 1 ns later (well before the next rising edge).
// Expected values adapt to whether NPC_RAS_PREDICT_EN is defined.
// -----------------------------------------------------------------------------
module tb_npc_gen;
   import npc_gen_pkg::*;

`ifdef NPC_RAS_PREDICT_EN
   localparam bit RAS_EN = 1'b1;
`else
   localparam bit RAS_EN = 1'b0;
`endif

   typedef struct {
      logic        rst;
      logic        pause;
      logic        recover;
      logic [31:0] recover_pc;
      logic        pd_valid;
      logic [31:0] pd_pc;
      logic        is_link;
      logic        is_return;
      logic        is_jump;
      logic [31:0] jump_target;
      logic [31:0] ras_target;
      logic [31:0] exp_pc;
      logic        exp_valid;
      logic        exp_push;
      logic        exp_pop;
      logic        chk_link;
      logic [31:0] exp_link;
   } vec_t;

   typedef struct {
      int          idx;
      logic [31:0] pc;
      logic        valid;
      logic        push;
      logic        pop;
      logic        chk_link;
      logic [31:0] link;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   compared   = 0;
   int   mismatched = 0;
   int   n_vec      = 0;

   vec_t vecs[$];
   exp_t sb[$];

   npc_gen_if bus ();

   npc_gen #(.RESET_PC(32'hBFC0_0000)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic [31:0] pc);
      vec_t v;
      v.rst = 1'b1;          v.pause = 1'b0;      v.recover = 1'b0;
      v.recover_pc = '0;     v.pd_valid = 1'b0;   v.pd_pc = '0;
      v.is_link = 1'b0;      v.is_return = 1'b0;  v.is_jump = 1'b0;
      v.jump_target = '0;    v.ras_target = '0;   v.exp_pc = pc;
      v.exp_valid = 1'b1;    v.exp_push = 1'b0;   v.exp_pop = 1'b0;
      v.chk_link = 1'b0;     v.exp_link = '0;
      return v;
   endfunction

   task automatic cmp(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
      end
   endtask

   task automatic apply_vec(input vec_t v);
      exp_t e;
      @(negedge clk);
      rst                = v.rst;
      bus.pause          = v.pause;
      bus.recover        = v.recover;
      bus.recover_pc     = v.recover_pc;
      bus.pd_valid       = v.pd_valid;
      bus.pd_pc          = v.pd_pc;
      bus.pd_isLink      = v.is_link;
      bus.pd_isReturn    = v.is_return;
      bus.pd_isJump      = v.is_jump;
      bus.pd_jump_target = v.jump_target;
      bus.ras_target     = v.ras_target;
      e.idx = n_vec; e.pc = v.exp_pc; e.valid = v.exp_valid; e.push = v.exp_push;
      e.pop = v.exp_pop; e.chk_link = v.chk_link; e.link = v.exp_link;
      sb.push_back(e);
      n_vec++;
      #1;
      if (sb.size() == 0) begin
         compared++;
         mismatched++;
         $display("FAIL scoreboard: empty queue got 0 expected 1 entry");
      end else begin
         e = sb.pop_front();
         $display("vec %0d: rst=%b pause=%b rec=%b pc=%h valid=%b push=%b pop=%b link=%h",
                  e.idx, rst, bus.pause, bus.recover, bus.fetch_pc, bus.fetch_valid,
                  bus.ras_push, bus.ras_pop, bus.ras_link_pc);
         cmp("fetch_pc",    e.idx, bus.fetch_pc,           e.pc);
         cmp("fetch_valid", e.idx, {31'd0, bus.fetch_valid}, {31'd0, e.valid});
         cmp("ras_push",    e.idx, {31'd0, bus.ras_push},  {31'd0, e.push});
         cmp("ras_pop",     e.idx, {31'd0, bus.ras_pop},   {31'd0, e.pop});
         if (e.chk_link) cmp("ras_link_pc", e.idx, bus.ras_link_pc, e.link);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t        v;
      logic [31:0] b_pc;
      logic [31:0] c_pc;
      b_pc = RAS_EN ? 32'hBFC0_0018 : 32'h8000_1010;
      c_pc = RAS_EN ? 32'h8000_3000 : 32'hDEAD_BEE0;

      bus.pause = 1'b0; bus.recover = 1'b0; bus.recover_pc = '0; bus.pd_valid = 1'b0;
      bus.pd_pc = '0; bus.pd_isLink = 1'b0; bus.pd_isReturn = 1'b0; bus.pd_isJump = 1'b0;
      bus.pd_jump_target = '0; bus.ras_target = '0;

      // Reset, BOOT, sequential fetch
      v = mk(32'hBFC0_0000); v.rst = 1'b0; v.exp_valid = 1'b0; vecs.push_back(v);
      v = mk(32'hBFC0_0000); v.exp_valid = 1'b0; vecs.push_back(v);
      for (int k = 0; k < 5; k++) vecs.push_back(mk(32'hBFC0_0000 + 32'(4 * k)));
      // jal in the shadow of BFC00014
      v = mk(32'hBFC0_0014); v.pd_valid = 1'b1; v.pd_pc = 32'hBFC0_0010; v.is_link = 1'b1;
      v.is_jump = 1'b1; v.jump_target = 32'h8000_1000; v.exp_push = RAS_EN;
      v.chk_link = 1'b1; v.exp_link = 32'hBFC0_0018; vecs.push_back(v);
      vecs.push_back(mk(32'h8000_1000));
      // Stale predecode is ignored
      v = mk(32'h8000_1004); v.pd_valid = 1'b1; v.pd_pc = 32'h8000_0FF0; v.is_jump = 1'b1;
      v.jump_target = 32'h1234_5678; vecs.push_back(v);
      vecs.push_back(mk(32'h8000_1008));
      // jr ra under a 3-cycle pause
      v = mk(32'h8000_100C); v.pd_valid = 1'b1; v.pd_pc = 32'h8000_1008; v.is_return = 1'b1;
      v.ras_target = 32'hBFC0_0018; v.pause = 1'b1; vecs.push_back(v);
      v = mk(32'h8000_100C); v.pause = 1'b1; vecs.push_back(v);
      v = mk(32'h8000_100C); v.pause = 1'b1; vecs.push_back(v);
      v = mk(32'h8000_100C); v.exp_pop = RAS_EN; vecs.push_back(v);
      vecs.push_back(mk(b_pc));
      // jalr ra,ra: pop-then-push
      v = mk(b_pc + 32'd4); v.pd_valid = 1'b1; v.pd_pc = b_pc; v.is_link = 1'b1;
      v.is_return = 1'b1; v.ras_target = 32'h8000_3000; v.jump_target = 32'hDEAD_BEE0;
      v.exp_push = RAS_EN; v.exp_pop = RAS_EN; v.chk_link = 1'b1; v.exp_link = b_pc + 32'd8;
      vecs.push_back(v);
      vecs.push_back(mk(c_pc));
      // recover beats an accepted jump under pause
      v = mk(c_pc + 32'd4); v.pd_valid = 1'b1; v.pd_pc = c_pc; v.is_jump = 1'b1; v.is_link = 1'b1;
      v.jump_target = 32'h1111_0000; v.pause = 1'b1; v.recover = 1'b1;
      v.recover_pc = 32'h8000_2000; vecs.push_back(v);
      vecs.push_back(mk(32'h8000_2000));
      vecs.push_back(mk(32'h8000_2004));
      // recover during HOLD discards the parked redirect
      v = mk(32'h8000_2008); v.pd_valid = 1'b1; v.pd_pc = 32'h8000_2004; v.is_jump = 1'b1;
      v.jump_target = 32'h2222_0000; v.pause = 1'b1; vecs.push_back(v);
      v = mk(32'h8000_2008); v.pause = 1'b1; vecs.push_back(v);
      v = mk(32'h8000_2008); v.pause = 1'b1; v.recover = 1'b1; v.recover_pc = 32'h8000_4000;
      vecs.push_back(v);
      vecs.push_back(mk(32'h8000_4000));
      vecs.push_back(mk(32'h8000_4004));
      // deferred push of a paused jal, issued on HOLD exit
      v = mk(32'h8000_4008); v.pd_valid = 1'b1; v.pd_pc = 32'h8000_4004; v.is_link = 1'b1;
      v.is_jump = 1'b1; v.jump_target = 32'h3333_0000; v.pause = 1'b1;
      v.chk_link = 1'b1; v.exp_link = 32'h8000_400C; vecs.push_back(v);
      v = mk(32'h8000_4008); v.exp_push = RAS_EN; v.chk_link = 1'b1; v.exp_link = 32'h8000_400C;
      vecs.push_back(v);
      vecs.push_back(mk(32'h3333_0000));
      // wrap at the top of the address space
      v = mk(32'h3333_0004); v.recover = 1'b1; v.recover_pc = 32'hFFFF_FFF8; vecs.push_back(v);
      vecs.push_back(mk(32'hFFFF_FFF8));
      vecs.push_back(mk(32'hFFFF_FFFC));
      vecs.push_back(mk(32'h0000_0000));
      vecs.push_back(mk(32'h0000_0004));
      // reset asserted mid-HOLD drops the parked redirect and push
      v = mk(32'h0000_0008); v.pd_valid = 1'b1; v.pd_pc = 32'h0000_0004; v.is_link = 1'b1;
      v.is_jump = 1'b1; v.jump_target = 32'h4444_0000; v.pause = 1'b1; vecs.push_back(v);
      v = mk(32'h0000_0008); v.pause = 1'b1; vecs.push_back(v);
      v = mk(32'hBFC0_0000); v.rst = 1'b0; v.exp_valid = 1'b0; vecs.push_back(v);
      v = mk(32'hBFC0_0000); v.exp_valid = 1'b0; vecs.push_back(v);
      vecs.push_back(mk(32'hBFC0_0000));
      vecs.push_back(mk(32'hBFC0_0004));

      for (int i = 0; i < vecs.size(); i++) apply_vec(vecs[i]);

      // Hand sequence: plain stall in RUN holds the address, then resumes.
      for (int k = 0; k < 4; k++) begin
         v = mk(32'hBFC0_0008); v.pause = 1'b1; apply_vec(v);
      end
      apply_vec(mk(32'hBFC0_0008));
      apply_vec(mk(32'hBFC0_000C));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
